// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sched
//  Description : Eight-input interrupt scheduler. Edge-triggered request
//                register, CPU-programmable mask, fully nested in-service
//                register, EOI command handling and the two-strobe INTA
//                sequence that places the vector on the CPU data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sched #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [7:0]  VEC_BASE = 8'h08
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic               iWr,
  input  logic               iRd,
  input  logic               iA0,
  input  logic [7:0]         iWrData,
  output logic [7:0]         oRdData,
  input  logic               iIntAck,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oVec
);

  localparam int                 IDX_W      = 3;
  localparam logic [NUM_IRQ-1:0] C_ONE      = NUM_IRQ'(1);
  localparam logic [7:0]         C_CMD_NSEOI = 8'h20;
  localparam logic [4:0]         C_CMD_SEOI  = 5'b01100;
  localparam logic [7:0]         C_CMD_RDIRR = 8'h0A;
  localparam logic [7:0]         C_CMD_RDISR = 8'h0B;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK1 = 1'b1
  } state_t;

  // Registered state
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               rdsel_q, rdsel_d;   // 0 = IRR, 1 = ISR
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic               int_q, int_d;
  logic               sel_q, sel_d;
  logic [7:0]         vec_q, vec_d;

  // Combinational helpers
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_isr_low;
  logic [NUM_IRQ-1:0] w_allowed;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_win_onehot;
  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_cmd_wr;
  logic               w_eoi_ns;
  logic               w_eoi_sp;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic               w_ack_take;
  logic [NUM_IRQ-1:0] w_ack_set;

  // Rising-edge detect; a line already high out of reset counts as an edge
  // because irq_q resets to zero.
  assign w_edge = iIrq & ~irq_q;

  // Lowest set in-service bit; only requests strictly below it may interrupt.
  assign w_isr_low = isr_q & (-isr_q);
  assign w_allowed = (isr_q == '0) ? '1 : (w_isr_low - C_ONE);
  assign w_cand    = irr_q & ~imr_q & w_allowed;

  assign w_win_valid  = |w_cand;
  assign w_win_onehot = w_cand & (-w_cand);

  // Priority encoder: lowest index wins, so scan downward and let it overwrite.
  always_comb begin
    w_win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_idx = IDX_W'(i);
      end
    end
  end

  // Command decode: EOI variants act on the pre-cycle ISR.
  assign w_cmd_wr  = iWr & ~iA0;
  assign w_eoi_ns  = w_cmd_wr && (iWrData == C_CMD_NSEOI);
  assign w_eoi_sp  = w_cmd_wr && (iWrData[7:3] == C_CMD_SEOI);
  assign w_eoi_clr = (w_eoi_ns ? w_isr_low : '0)
                   | (w_eoi_sp ? (C_ONE << iWrData[2:0]) : '0);

  // First INTA strobe with a winner moves the request into service.
  assign w_ack_take = (state_q == S_IDLE) && iIntAck && w_win_valid;
  assign w_ack_set  = w_ack_take ? w_win_onehot : '0;

  // Register-file next state; new edges override an acknowledge clear.
  always_comb begin
    irr_d   = (irr_q & ~w_ack_set) | w_edge;
    isr_d   = (isr_q & ~w_eoi_clr) | w_ack_set;
    imr_d   = (iWr && iA0) ? iWrData : imr_q;
    rdsel_d = rdsel_q;
    if (w_cmd_wr && (iWrData == C_CMD_RDIRR)) begin
      rdsel_d = 1'b0;
    end else if (w_cmd_wr && (iWrData == C_CMD_RDISR)) begin
      rdsel_d = 1'b1;
    end
  end

  // INTA sequencer: first strobe latches the winner, second emits the vector.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sel_d   = 1'b0;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (iIntAck) begin
          cur_d   = w_win_valid ? w_win_idx : IDX_W'(7);
          state_d = S_ACK1;
        end
      end
      S_ACK1: begin
        if (iIntAck) begin
          sel_d   = 1'b1;
          vec_d   = VEC_BASE + 8'(cur_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Request is held low for the whole acknowledge window.
    int_d = (state_d == S_IDLE) && w_win_valid;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= '0;
      irq_q   <= '0;
      rdsel_q <= 1'b0;
      state_q <= S_IDLE;
      cur_q   <= '0;
      int_q   <= 1'b0;
      sel_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      irq_q   <= iIrq;
      rdsel_q <= rdsel_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      int_q   <= int_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
    end
  end

  // Read mux is purely combinational and side-effect free.
  always_comb begin
    oRdData = '0;
    if (iRd) begin
      if (iA0) begin
        oRdData = imr_q;
      end else begin
        oRdData = rdsel_q ? isr_q : irr_q;
      end
    end
  end

  assign oInt = int_q;
  assign oSel = sel_q;
  assign oVec = vec_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_sched
//  Description : Self-checking bench for irq_sched: vector table, directed
//                multi-cycle sequences and randomized traffic against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       wr, rd, a0, ack;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       o_int, o_sel;
  logic [7:0] o_vec;

  int errors = 0;
  int checks = 0;
  bit chk_model = 0;

  irq_sched #(.NUM_IRQ(8), .VEC_BASE(8'h08)) dut (
    .iClk(clk), .iRst(rst), .iIrq(irq), .iWr(wr), .iRd(rd), .iA0(a0),
    .iWrData(wdata), .oRdData(rdata), .iIntAck(ack),
    .oInt(o_int), .oSel(o_sel), .oVec(o_vec)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [7:0] m_irr, m_isr, m_imr, m_prev, m_vec;
  bit       m_rdsel, m_ack1, m_int, m_sel;
  int       m_cur;

  function automatic int lowest(input bit [7:0] v);
    for (int n = 0; n < 8; n++) if (v[n]) return n;
    return 8;
  endfunction

  function automatic int m_winner();
    int low = lowest(m_isr);
    for (int n = 0; n < 8; n++)
      if (m_irr[n] && !m_imr[n] && n < low) return n;
    return -1;
  endfunction

  function automatic bit [7:0] m_rd();
    if (!rd) return 8'h00;
    if (a0) return m_imr;
    return m_rdsel ? m_isr : m_irr;
  endfunction

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_imr = 0; m_prev = 0; m_vec = 0;
    m_rdsel = 0; m_ack1 = 0; m_int = 0; m_sel = 0; m_cur = 0;
  endtask

  task automatic model_clock();
    int w, low;
    bit [7:0] n_irr, n_isr;
    w = m_winner();
    n_irr = m_irr;
    n_isr = m_isr;
    if (wr && !a0) begin
      if (wdata == 8'h20) begin
        low = lowest(m_isr);
        if (low < 8) n_isr[low] = 1'b0;
      end else if (wdata >= 8'h60 && wdata <= 8'h67) begin
        n_isr[wdata - 8'h60] = 1'b0;
      end else if (wdata == 8'h0A) begin
        m_rdsel = 0;
      end else if (wdata == 8'h0B) begin
        m_rdsel = 1;
      end
    end
    if (wr && a0) m_imr = wdata;
    m_sel = 0;
    if (!m_ack1) begin
      if (ack) begin
        if (w >= 0) begin
          n_isr[w] = 1'b1;
          n_irr[w] = 1'b0;
          m_cur = w;
        end else begin
          m_cur = 7;
        end
        m_ack1 = 1;
      end
    end else if (ack) begin
      m_vec  = 8'(8 + m_cur);
      m_sel  = 1;
      m_ack1 = 0;
    end
    for (int n = 0; n < 8; n++)
      if (irq[n] && !m_prev[n]) n_irr[n] = 1'b1;
    m_prev = irq;
    m_irr  = n_irr;
    m_isr  = n_isr;
    m_int  = !m_ack1 && (w >= 0);
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    if (rst) model_reset(); else model_clock();
    @(posedge clk);
    #1;
    if (chk_model) begin
      chk("rnd_int", {7'd0, o_int}, {7'd0, m_int});
      chk("rnd_sel", {7'd0, o_sel}, {7'd0, m_sel});
      chk("rnd_vec", o_vec, m_vec);
      chk("rnd_rd",  rdata, m_rd());
    end
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    wr = 1; a0 = a; wdata = d;
    cyc();
    wr = 0; a0 = 0; wdata = 0;
  endtask

  task automatic ack_pulse();
    ack = 1;
    cyc();
    ack = 0;
  endtask

  task automatic rdchk(input string name, input logic a, input logic [7:0] exp);
    rd = 1; a0 = a;
    #1;
    chk(name, rdata, exp);
    rd = 0; a0 = 0;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0] irq;
    logic       wr;
    logic       a0;
    logic [7:0] wd;
    logic       rd;
    logic       ack;
    logic       e_int;
    logic       e_sel;
    logic [7:0] e_vec;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [0:31];
  int   n_tbl = 0;

  task automatic add(input logic [7:0] i, input logic w, input logic a, input logic [7:0] d,
                     input logic r, input logic k, input logic ei, input logic es,
                     input logic [7:0] ev, input logic [7:0] er);
    tbl[n_tbl].irq = i;  tbl[n_tbl].wr = w;     tbl[n_tbl].a0 = a;
    tbl[n_tbl].wd  = d;  tbl[n_tbl].rd = r;     tbl[n_tbl].ack = k;
    tbl[n_tbl].e_int = ei; tbl[n_tbl].e_sel = es;
    tbl[n_tbl].e_vec = ev; tbl[n_tbl].e_rd = er;
    n_tbl++;
  endtask

  initial begin
    rst = 1; irq = 0; wr = 0; rd = 0; a0 = 0; ack = 0; wdata = 0;
    model_reset();

    //   irq   wr a0 data  rd ack  int sel vec    rd
    add(8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00);
    add(8'h02, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00);
    add(8'h02, 0, 0, 8'h00, 1, 0,  1, 0, 8'h00, 8'h02);
    add(8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1,  0, 1, 8'h09, 8'h00);
    add(8'h00, 1, 0, 8'h0B, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h09, 8'h02);
    add(8'h00, 1, 0, 8'h0A, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 1, 1, 8'h5A, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 1, 8'h00, 1, 0,  0, 0, 8'h09, 8'h5A);
    add(8'h00, 1, 1, 8'h00, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 1, 0, 8'h20, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 1, 0, 8'h0B, 0, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 8'h09, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1,  0, 1, 8'h0F, 8'h00);
    add(8'h00, 0, 0, 8'h00, 1, 0,  0, 0, 8'h0F, 8'h00);

    // Reset state
    cyc(); cyc();
    chk("rst_int", {7'd0, o_int}, 8'h00);
    chk("rst_sel", {7'd0, o_sel}, 8'h00);
    chk("rst_vec", o_vec, 8'h00);
    rdchk("rst_irr", 1'b0, 8'h00);
    rdchk("rst_imr", 1'b1, 8'h00);
    rst = 0;

    // Table: basic acknowledge, register access, spurious acknowledge
    for (int r = 0; r < n_tbl; r++) begin
      irq = tbl[r].irq; wr = tbl[r].wr; a0 = tbl[r].a0; wdata = tbl[r].wd;
      rd = tbl[r].rd; ack = tbl[r].ack;
      cyc();
      chk($sformatf("tbl%0d_int", r), {7'd0, o_int}, {7'd0, tbl[r].e_int});
      chk($sformatf("tbl%0d_sel", r), {7'd0, o_sel}, {7'd0, tbl[r].e_sel});
      chk($sformatf("tbl%0d_vec", r), o_vec, tbl[r].e_vec);
      chk($sformatf("tbl%0d_rd", r),  rdata, tbl[r].e_rd);
      wr = 0; rd = 0; ack = 0; a0 = 0; wdata = 0;
    end

    // Nesting: IRQ1 in service blocks IRQ3, IRQ0 preempts
    irq = 8'h02; cyc(); cyc();
    chk("nest_int1", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("nest_vec1", o_vec, 8'h09);
    irq = 8'h0A; cyc(); cyc();
    chk("nest_blk3", {7'd0, o_int}, 8'h00);
    irq = 8'h0B; cyc(); cyc();
    chk("nest_int0", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("nest_sel0", {7'd0, o_sel}, 8'h01);
    chk("nest_vec0", o_vec, 8'h08);
    wr_reg(1'b0, 8'h0B);
    rdchk("nest_isr03", 1'b0, 8'h03);
    wr_reg(1'b0, 8'h20);
    rdchk("nest_isr02", 1'b0, 8'h02);
    cyc();
    chk("nest_still_blk", {7'd0, o_int}, 8'h00);
    wr_reg(1'b0, 8'h20);
    rdchk("nest_isr00", 1'b0, 8'h00);
    cyc();
    chk("nest_int3", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("nest_vec3", o_vec, 8'h0B);
    wr_reg(1'b0, 8'h20);
    irq = 8'h00; cyc();

    // Mask holds a request pending until unmasked
    wr_reg(1'b1, 8'h01);
    irq = 8'h01; cyc(); cyc(); cyc();
    chk("mask_int0", {7'd0, o_int}, 8'h00);
    wr_reg(1'b0, 8'h0A);
    rdchk("mask_irr", 1'b0, 8'h01);
    wr_reg(1'b1, 8'h00);
    cyc();
    chk("mask_int1", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("mask_vec", o_vec, 8'h08);
    wr_reg(1'b0, 8'h20);
    irq = 8'h00; cyc();

    // New edge on the line being acknowledged keeps IRR set
    irq = 8'h04; cyc(); cyc();
    irq = 8'h00; cyc();
    chk("edge_int", {7'd0, o_int}, 8'h01);
    irq = 8'h04; ack = 1; cyc(); ack = 0;
    wr_reg(1'b0, 8'h0A);
    rdchk("edge_irr", 1'b0, 8'h04);
    ack_pulse();
    chk("edge_vec1", o_vec, 8'h0A);
    wr_reg(1'b0, 8'h62);
    cyc();
    chk("edge_int2", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("edge_vec2", o_vec, 8'h0A);
    wr_reg(1'b0, 8'h62);
    irq = 8'h00; cyc();

    // Asynchronous reset between the two strobes
    irq = 8'h02; cyc(); cyc();
    ack_pulse();
    irq = 8'h00;
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("arst_int", {7'd0, o_int}, 8'h00);
    chk("arst_vec", o_vec, 8'h00);
    rdchk("arst_irr", 1'b0, 8'h00);
    rdchk("arst_imr", 1'b1, 8'h00);
    ack_pulse();
    chk("arst_sel", {7'd0, o_sel}, 8'h00);
    rst = 0;
    ack_pulse();
    chk("arst_idle", {7'd0, o_sel}, 8'h00);
    ack_pulse();
    chk("arst_spur_sel", {7'd0, o_sel}, 8'h01);
    chk("arst_spur_vec", o_vec, 8'h0F);
    wr_reg(1'b0, 8'h0B);
    rdchk("arst_isr", 1'b0, 8'h00);
    irq = 8'h02; cyc(); cyc();
    chk("arst_int1", {7'd0, o_int}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("arst_vec9", o_vec, 8'h09);
    wr_reg(1'b0, 8'h20);
    irq = 8'h00; cyc();

    // Randomized traffic against the reference model
    chk_model = 1;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
      ack = ($urandom_range(0, 3) == 0);
      wr  = ($urandom_range(0, 5) == 0);
      a0  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      if (wr && a0) begin
        wdata = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end else begin
        case ($urandom_range(0, 4))
          0:       wdata = 8'h20;
          1:       wdata = 8'h60 | 8'($urandom_range(0, 7));
          2:       wdata = 8'h0A;
          3:       wdata = 8'h0B;
          default: wdata = 8'($urandom);
        endcase
      end
      cyc();
    end
    chk_model = 0;
    wr = 0; rd = 0; ack = 0; a0 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
